note_player: RTL

// - Consumer end of the note handshake: accepts new_note with note/duration from the song reader,

---
 rtl/note_player_pkg.sv | 39 +++
 rtl/note_player_if.sv | 31 +++
 rtl/note_step_rom.sv | 23 ++
 rtl/note_player.sv | 130 +++++++++++++
 4 files changed

// File: rtl/note_player_pkg.sv
// Shared types and constants for the note player.
// Holds the FSM encoding, the rest note index and the phase-step table.
package note_player_pkg;

    localparam int NP_ACC_W  = 20;
    localparam int NP_NOTE_W = 6;
    localparam int NP_DUR_W  = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [NP_NOTE_W-1:0] NOTE_REST = '0;

    // Equal-tempered steps; index 20 is exactly 2^14 (half period 32 clk)
    localparam logic [NP_ACC_W-1:0] STEP_TABLE [64] = '{
        20'd0,
        20'd5468,   20'd5793,   20'd6137,   20'd6502,
        20'd6889,   20'd7298,   20'd7732,
        20'd8192,   20'd8679,   20'd9195,   20'd9742,
        20'd10321,  20'd10935,  20'd11585,  20'd12274,
        20'd13004,  20'd13777,  20'd14596,  20'd15464,
        20'd16384,  20'd17358,  20'd18390,  20'd19484,
        20'd20643,  20'd21870,  20'd23170,  20'd24548,
        20'd26008,  20'd27554,  20'd29193,  20'd30929,
        20'd32768,  20'd34716,  20'd36781,  20'd38968,
        20'd41285,  20'd43740,  20'd46341,  20'd49096,
        20'd52016,  20'd55109,  20'd58386,  20'd61858,
        20'd65536,  20'd69433,  20'd73562,  20'd77936,
        20'd82570,  20'd87480,  20'd92682,  20'd98193,
        20'd104032, 20'd110218, 20'd116772, 20'd123716,
        20'd131072, 20'd138866, 20'd147123, 20'd155872,
        20'd165140, 20'd174960, 20'd185364, 20'd196386
    };

endpackage

// File: rtl/note_player_if.sv
// Note handshake between the song reader (master) and the player (slave).
interface note_player_if
    import note_player_pkg::*;
#(
    parameter int NOTE_W = NP_NOTE_W,
    parameter int DUR_W  = NP_DUR_W
);

    logic              new_note;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
    logic              note_done;
    logic              busy;

    modport master (
        output new_note,
        output note,
        output duration,
        input  note_done,
        input  busy
    );

    modport slave (
        input  new_note,
        input  note,
        input  duration,
        output note_done,
        output busy
    );

endinterface

// File: rtl/note_step_rom.sv
// Registered phase-step lookup; one cycle from address to step.
module note_step_rom
    import note_player_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NP_NOTE_W-1:0] i_addr,
    output logic [NP_ACC_W-1:0]  o_step
);

    logic [NP_ACC_W-1:0] r_step;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_step <= '0;
        end else begin
            r_step <= STEP_TABLE[i_addr];
        end
    end

    assign o_step = r_step;

endmodule

// File: rtl/note_player.sv
// Plays one note as a square wave for a number of beats, then pulses note_done.
// Define NOTE_PLAYER_GAP_EN to silence the final beat of notes lasting 2+ beats.
module note_player
    import note_player_pkg::*;
#(
    parameter int ACC_W  = NP_ACC_W,
    parameter int NOTE_W = NP_NOTE_W,
    parameter int DUR_W  = NP_DUR_W
)
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         play,
    input  logic         beat,
    note_player_if.slave np,
    output logic         tone
);

    state_t            r_state;
    logic [NOTE_W-1:0] r_note;
    logic [DUR_W-1:0]  r_dur;
    logic [DUR_W-1:0]  r_beat_cnt;
    logic [ACC_W-1:0]  r_acc;
    logic              r_done;
    logic              r_busy;
    logic              r_tone;

    logic [NP_ACC_W-1:0] w_step_rom;
    logic [ACC_W-1:0]    w_step;
    logic [ACC_W-1:0]    w_acc_sum;
    logic [DUR_W-1:0]    w_cnt_inc;
    logic [DUR_W-1:0]    w_cnt_nxt;
    logic                w_run;
    logic                w_tick;
    logic                w_last;
    logic                w_gap;

    // ROM is addressed by the latched note, so its output settles during LOAD
    note_step_rom u_rom (
        .clk     (clk),
        .reset_n (reset_n),
        .i_addr  (NP_NOTE_W'(r_note)),
        .o_step  (w_step_rom)
    );

    assign w_step    = ACC_W'(w_step_rom);
    assign w_acc_sum = r_acc + w_step;
    assign w_run     = play && (r_note != NOTE_W'(NOTE_REST));
    assign w_tick    = beat && play;
    assign w_cnt_inc = r_beat_cnt + DUR_W'(1);
    assign w_last    = w_tick && (w_cnt_inc == r_dur);
    assign w_cnt_nxt = w_tick ? w_cnt_inc : r_beat_cnt;

`ifdef NOTE_PLAYER_GAP_EN
    assign w_gap = (r_dur >= DUR_W'(2)) &&
                   (w_cnt_nxt == r_dur - DUR_W'(1));
`else
    assign w_gap = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_note     <= '0;
            r_dur      <= '0;
            r_beat_cnt <= '0;
            r_acc      <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_tone     <= 1'b0;
        end else if (np.new_note) begin
            // A new note always wins, aborting whatever is in flight
            r_state    <= ST_LOAD;
            r_note     <= np.note;
            r_dur      <= np.duration;
            r_beat_cnt <= '0;
            r_acc      <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b1;
            r_tone     <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    r_tone <= 1'b0;
                end
                ST_LOAD: begin
                    r_acc      <= '0;
                    r_beat_cnt <= '0;
                    r_tone     <= 1'b0;
                    if (r_dur == '0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_PLAY;
                        r_busy  <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (w_run) begin
                        r_acc <= w_acc_sum;
                    end
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_tone  <= 1'b0;
                    end else begin
                        r_beat_cnt <= w_cnt_nxt;
                        r_tone     <= w_run && !w_gap &&
                                      w_acc_sum[ACC_W-1];
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_tone  <= 1'b0;
                end
            endcase
        end
    end

    assign np.note_done = r_done;
    assign np.busy      = r_busy;
    assign tone         = r_tone;

endmodule
